// File: rtl/ring_decoder_if.sv
// Ring decoder sample/result bundle.
// rev_cnt exists only when RING_DEC_REVCNT_EN is defined.
interface ring_decoder_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  ring_in;
  logic          ring_vld;
  logic [IW-1:0] idx;
  logic          idx_vld;
  logic          locked;
  logic          err;
  logic [7:0]    err_cnt;
`ifdef RING_DEC_REVCNT_EN
  logic [15:0]   rev_cnt;
`endif

  modport master (
    output ring_in, ring_vld,
    input  idx, idx_vld, locked, err,
`ifdef RING_DEC_REVCNT_EN
    input  rev_cnt,
`endif
    input  err_cnt
  );

  modport slave (
    input  ring_in, ring_vld,
    output idx, idx_vld, locked, err,
`ifdef RING_DEC_REVCNT_EN
    output rev_cnt,
`endif
    output err_cnt
  );
endinterface

// File: rtl/ring_decoder.sv
// One-hot ring code checker/decoder with lock tracking and fault count.
// Optional revolution counter enabled by RING_DEC_REVCNT_EN.
module ring_decoder #(
  parameter int N      = 4,
  parameter int DIR    = 0,
  parameter int LOCK_N = 2
) (
  input  logic clk,
  input  logic rst,
  ring_decoder_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {
    HUNT,
    ACQ,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          idx_vld_q, idx_vld_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
`ifdef RING_DEC_REVCNT_EN
  logic [15:0]   rev_cnt_q, rev_cnt_d;
  logic          wrap_src;
`endif

  logic          onehot;
  logic          hit;
  logic [N-1:0]  exp_code;
  logic [IW-1:0] enc;

  always_comb begin
    onehot = $onehot(bus.ring_in);
    if (DIR == 0) begin
      exp_code = {ref_q[N-2:0], ref_q[N-1]};
    end else begin
      exp_code = {ref_q[0], ref_q[N-1:1]};
    end
    hit = (bus.ring_in == exp_code);
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.ring_in[i]) enc = IW'(i);
    end
  end

`ifdef RING_DEC_REVCNT_EN
  // A wrap is leaving the end bit in the rotation direction
  assign wrap_src = (DIR == 0) ? ref_q[N-1] : ref_q[0];
`endif

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    idx_vld_d = 1'b0;
    err_d     = 1'b0;
`ifdef RING_DEC_REVCNT_EN
    rev_cnt_d = rev_cnt_q;
`endif
    if (bus.ring_vld) begin
      if (onehot) begin
        idx_d     = enc;
        idx_vld_d = 1'b1;
      end
      case (state_q)
        HUNT: begin
          if (onehot) begin
            ref_d   = bus.ring_in;
            cnt_d   = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (!onehot) begin
            state_d = HUNT;
          end else if (hit) begin
            ref_d = bus.ring_in;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(LOCK_N)) state_d = LOCKED;
          end else begin
            ref_d = bus.ring_in;
            cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!onehot) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (hit) begin
            ref_d = bus.ring_in;
`ifdef RING_DEC_REVCNT_EN
            if (wrap_src) rev_cnt_d = rev_cnt_q + 16'd1;
`endif
          end else begin
            err_d   = 1'b1;
            ref_d   = bus.ring_in;
            cnt_d   = '0;
            state_d = ACQ;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d  = (state_d == LOCKED);
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      ref_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef RING_DEC_REVCNT_EN
      rev_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      idx_vld_q <= idx_vld_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef RING_DEC_REVCNT_EN
      rev_cnt_q <= rev_cnt_d;
`endif
    end
  end

  assign bus.idx     = idx_q;
  assign bus.idx_vld = idx_vld_q;
  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
`ifdef RING_DEC_REVCNT_EN
  assign bus.rev_cnt = rev_cnt_q;
`endif
endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder (N=4, DIR=0, LOCK_N=2).
// Define RING_DEC_REVCNT_EN to also cover the revolution counter.
module tb_ring_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ring_decoder_if #(.N(4)) bus ();

  ring_decoder #(
    .N(4),
    .DIR(0),
    .LOCK_N(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  idx;
    logic        vld;
    logic        lck;
    logic        err;
    logic [7:0]  ecnt;
    logic        chk_rev;
    logic [15:0] rev;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  string tag = "init";
  logic rev_chk = 1'b0;
  logic [15:0] rev_exp = '0;

  task automatic step(input logic r, input logic [3:0] code,
                      input logic v, input logic [1:0] e_idx,
                      input logic e_vld, input logic e_lck,
                      input logic e_err, input logic [7:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.ring_in = code;
    bus.ring_vld = v;
    e.tag = tag;
    e.idx = e_idx;
    e.vld = e_vld;
    e.lck = e_lck;
    e.err = e_err;
    e.ecnt = e_cnt;
    e.chk_rev = rev_chk;
    e.rev = rev_exp;
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        logic [15:0] rv;
        e = sb.pop_front();
        checks++;
        if (bus.idx !== e.idx || bus.idx_vld !== e.vld ||
            bus.locked !== e.lck || bus.err !== e.err ||
            bus.err_cnt !== e.ecnt) begin
          errors++;
          $display("FAIL %s: got idx=%0d vld=%b lck=%b err=%b cnt=%0d, want idx=%0d vld=%b lck=%b err=%b cnt=%0d",
                   e.tag, bus.idx, bus.idx_vld, bus.locked, bus.err,
                   bus.err_cnt, e.idx, e.vld, e.lck, e.err, e.ecnt);
        end
`ifdef RING_DEC_REVCNT_EN
        rv = bus.rev_cnt;
`else
        rv = '0;
`endif
        if (e.chk_rev) begin
          checks++;
          if (rv !== e.rev) begin
            errors++;
            $display("FAIL %s rev_cnt: got %0d want %0d", e.tag, rv, e.rev);
          end
        end
      end
    end
  end

  initial begin
    int c;
    bus.ring_in = '0;
    bus.ring_vld = 1'b0;

    tag = "reset";
    step(1, 4'b0001, 1, 0, 0, 0, 0, 0);
    step(1, 4'b0001, 1, 0, 0, 0, 0, 0);

    tag = "acquire";
    step(0, 4'b0001, 1, 0, 1, 0, 0, 0);
    step(0, 4'b0010, 1, 1, 1, 0, 0, 0);
    step(0, 4'b0100, 1, 2, 1, 1, 0, 0);
    step(0, 4'b1000, 1, 3, 1, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 1, 1, 0, 0);

    tag = "multibit";
    step(0, 4'b0010, 1, 1, 1, 1, 0, 0);
    step(0, 4'b0110, 1, 1, 0, 0, 1, 1);
    step(0, 4'b0100, 1, 2, 1, 0, 0, 1);
    step(0, 4'b1000, 1, 3, 1, 0, 0, 1);
    step(0, 4'b0001, 1, 0, 1, 1, 0, 1);

    tag = "skip";
    step(0, 4'b0100, 1, 2, 1, 0, 1, 2);
    step(0, 4'b1000, 1, 3, 1, 0, 0, 2);
    step(0, 4'b0001, 1, 0, 1, 1, 0, 2);

    tag = "gap";
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0110, 0, 0, 0, 1, 0, 2);
    end
    step(0, 4'b0010, 1, 1, 1, 1, 0, 2);

    tag = "repeat";
    step(0, 4'b0010, 1, 1, 1, 0, 1, 3);
    step(0, 4'b0100, 1, 2, 1, 0, 0, 3);
    step(0, 4'b1000, 1, 3, 1, 1, 0, 3);

    tag = "zero";
    step(0, 4'b0000, 1, 3, 0, 0, 1, 4);
    step(0, 4'b0000, 1, 3, 0, 0, 0, 4);

    tag = "saturate";
    c = 4;
    for (int i = 0; i < 300; i++) begin
      step(0, 4'b0001, 1, 0, 1, 0, 0, 8'(c));
      step(0, 4'b0010, 1, 1, 1, 0, 0, 8'(c));
      step(0, 4'b0100, 1, 2, 1, 1, 0, 8'(c));
      if (c < 255) c++;
      step(0, 4'b0000, 1, 2, 0, 0, 1, 8'(c));
    end

    tag = "rst_locked";
    step(0, 4'b0001, 1, 0, 1, 0, 0, 255);
    step(0, 4'b0010, 1, 1, 1, 0, 0, 255);
    step(0, 4'b0100, 1, 2, 1, 1, 0, 255);
    step(1, 4'b1000, 1, 0, 0, 0, 0, 0);
    step(0, 4'b1000, 0, 0, 0, 0, 0, 0);

`ifdef RING_DEC_REVCNT_EN
    tag = "revcnt";
    rev_chk = 1'b1;
    rev_exp = 0;
    step(0, 4'b0001, 1, 0, 1, 0, 0, 0);
    step(0, 4'b0010, 1, 1, 1, 0, 0, 0);
    step(0, 4'b0100, 1, 2, 1, 1, 0, 0);
    for (int r = 1; r <= 3; r++) begin
      step(0, 4'b1000, 1, 3, 1, 1, 0, 0);
      rev_exp = 16'(r);
      step(0, 4'b0001, 1, 0, 1, 1, 0, 0);
      step(0, 4'b0010, 1, 1, 1, 1, 0, 0);
      step(0, 4'b0100, 1, 2, 1, 1, 0, 0);
    end
    tag = "rev_hold";
    step(0, 4'b0001, 1, 0, 1, 0, 1, 1);
    step(0, 4'b0010, 1, 1, 1, 0, 0, 1);
    step(0, 4'b0100, 1, 2, 1, 1, 0, 1);
    rev_chk = 1'b0;
`endif

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to `ring_counter`: samples a one-hot ring code (4-bit for the default N), validates it, and decodes it to a binary index. It tracks the expected rotation sequence, acquires and holds lock, and flags and counts sequence faults. It sits downstream of any `ring_counter` instance, or its registered copy, whose state must be monitored or converted to binary.

## Interface
- `N`, default 4, ring width in bits (N ≥ 2).
- `DIR`, default 0. 0 means the ring rotates toward the MSB, so the index increments. 1 means it rotates toward the LSB, so the index decrements.
- `LOCK_N`, default 2, number of consecutive correct transitions required to enter LOCKED (LOCK_N ≥ 1).
- `IW`, default `$clog2(N)`, index width. Derived; not to be overridden.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ring_in`  in  N  ring code sample.
- `ring_vld`  in  1  `ring_in` is valid this cycle.
- `idx`  out  IW  decoded bit position of the last valid one-hot sample.
- `idx_vld`  out  1  `idx` updated from a valid one-hot sample on the previous edge.
- `locked`  out  1  decoder is in LOCKED.
- `err`  out  1  one-cycle pulse on a fault detected while LOCKED.
- `err_cnt`  out  8  saturating count of `err` pulses.
- `rev_cnt`  out  16  completed revolutions. Present only with `RING_DEC_REVCNT_EN`.

## Operation
- A sample is taken on any edge with `ring_vld`=1. With `ring_vld`=0 the FSM, counters and `idx` hold, and `idx_vld` is 0 in the following cycle.
- A sample is one-hot when exactly one bit is set. `0000` and any multi-bit value are invalid.
- The expected next code is the previous accepted code rotated by one position in the direction set by `DIR`. The wrap cases are bit N-1 → bit 0 for DIR=0 and bit 0 → bit N-1 for DIR=1.
- A repeated identical code counts as out-of-sequence.
- `idx` and `idx_vld` update on every one-hot sample in all states.
- An invalid sample sets `idx_vld`=0 and leaves `idx` unchanged.

FSM states: HUNT, ACQ, LOCKED. Reset enters HUNT.
- HUNT:
  - one-hot sample: store it as the reference, clear the transition count, go to ACQ.
  - invalid sample: stay in HUNT.
- ACQ:
  - expected code: store it and increment the count. When the count reaches LOCK_N, go to LOCKED.
  - other one-hot code: store it as the new reference, clear the count, stay in ACQ.
  - invalid sample: go to HUNT.
  - No `err` is raised in ACQ.
- LOCKED:
  - expected code: stay in LOCKED.
  - out-of-sequence one-hot code: pulse `err`, store the code as the reference, clear the count, go to ACQ.
  - invalid sample: pulse `err`, go to HUNT.
- `err_cnt` increments with each `err` pulse and saturates at 255.
- `rst` at any time, including mid-lock, overrides all other activity.

## Timing
- Every output is registered. The response to a sample taken at edge k is visible in the cycle after edge k, i.e. one cycle of latency.
- `locked` rises in the cycle after the edge that samples the LOCK_N-th correct transition.
- `locked` falls in the same cycle that `err` is high.
- `err` is high for exactly one cycle per fault. Back-to-back faults give back-to-back pulses only while LOCKED; the first fault exits LOCKED, so in practice there is one pulse per lock loss.
- Values during and after reset: `idx`=0, `idx_vld`=0, `locked`=0, `err`=0, `err_cnt`=0, `rev_cnt`=0.

## Configuration
- `RING_DEC_REVCNT_EN` defined:
  - the `rev_cnt` port and its logic are present.
  - `rev_cnt` increments when a correct wrap transition (the wrap cases above) is sampled while LOCKED.
  - It holds otherwise, wraps modulo 2^16, and is not cleared by loss of lock.
- `RING_DEC_REVCNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use the defaults N=4, DIR=0, LOCK_N=2.
- Reset, then samples `0001`, `0010`, `0100`, `1000`, `0001` on consecutive edges → `idx` = 0, 1, 2, 3, 0 with `idx_vld`=1 each cycle, and `locked`=1 from the cycle after the third sample.
- Locked at `0010`, then sample `0110` → `err` pulses once, `err_cnt`=1, `locked`=0, `idx_vld`=0, `idx` stays 1, FSM in HUNT. Next, `0100`, `1000`, `0001` → relock after the third of these.
- Locked at `0001`, then sample `0100` → `err` pulses, `idx`=2, FSM in ACQ. Then `1000`, `0001` → `locked`=1 again with no further `err`.
- Locked, then `ring_vld` low for 5 cycles, then the expected code → no `err`, `locked` stays 1, `idx_vld` is 0 during the gap.
- Force 300 lock/fault cycles → `err_cnt` stops at 255. Assert `rst` while locked → all outputs 0 the next cycle.
- With `RING_DEC_REVCNT_EN` defined: locked, then 3 full revolutions → `rev_cnt`=3. A fault follows → `rev_cnt` holds at 3.
